// File: rtl/freq_gen_nco_pkg.sv
// Shared definitions for the square-wave NCO: state encoding and default widths.
package freq_gen_nco_pkg;

    localparam int ACC_W_DEF = 32;
    localparam int CNT_W_DEF = 64;
    localparam int BURST_W   = 32;

    // Largest legal tuning word: half the accumulator range, toggling ch_out every clock.
    localparam logic [ACC_W_DEF-1:0] TW_MAX = {1'b1, {(ACC_W_DEF-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } nco_state_t;

endpackage

// File: rtl/freq_gen_nco_phase_acc.sv
// Phase accumulator: registered acc with adder and carry-out (wrap) flag.
module nco_phase_acc
    import freq_gen_nco_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [ACC_W-1:0] tw,
    output logic [ACC_W-1:0] acc,
    output logic             wrap
);

    logic [ACC_W:0] sum_p0;

    assign sum_p0 = {1'b0, acc} + {1'b0, tw};
    assign wrap   = en & sum_p0[ACC_W];

    // Stage p1: phase register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= sum_p0[ACC_W-1:0];
        end
    end

endmodule

// File: rtl/freq_gen_nco.sv
// Programmable square-wave generator: NCO phase accumulator, burst/stop control,
// glitch-free tuning-word updates at period boundaries and a rising-edge counter.
module freq_gen_nco
    import freq_gen_nco_pkg::*;
#(
    parameter int     ACC_W  = ACC_W_DEF,
    parameter longint CLK_HZ = 50_000_000,
    parameter int     CNT_W  = CNT_W_DEF
) (
    input  logic               sys_clk_50m,
    input  logic               sys_rst,
    input  logic [ACC_W-1:0]   tw_in,
    input  logic               tw_valid,
    output logic               tw_ready,
    input  logic [BURST_W-1:0] burst_len,
    input  logic               start,
    input  logic               stop,
    input  logic               clr_cnt,
    output logic               busy,
    output logic               done,
    output logic               ch_out,
    output logic [CNT_W-1:0]   edge_cnt
);

    if (ACC_W < 2) begin : g_bad_acc_w
        $error("ACC_W must be at least 2");
    end
    if (CLK_HZ <= 0) begin : g_bad_clk_hz
        $error("CLK_HZ must be positive");
    end

    localparam logic [ACC_W-1:0] TW_CLAMP = {1'b1, {(ACC_W-1){1'b0}}};

    function automatic logic [ACC_W-1:0] sat_tw(input logic [ACC_W-1:0] tw);
        return (tw > TW_CLAMP) ? TW_CLAMP : tw;
    endfunction

    nco_state_t         state_q, state_d;
    logic [ACC_W-1:0]   tw_active, tw_pend;
    logic               pend_vld;
    logic [BURST_W-1:0] burst_q, period_q, period_inc;
    logic [ACC_W-1:0]   acc;
    logic               wrap;
    logic               acc_en, acc_clr;
    logic               apply_pend, capture;
    logic               burst_end, zero_next;
    logic               ch_out_p1;

    nco_phase_acc #(
        .ACC_W (ACC_W)
    ) u_phase_acc (
        .clk  (sys_clk_50m),
        .rst  (sys_rst),
        .en   (acc_en),
        .clr  (acc_clr),
        .tw   (tw_active),
        .acc  (acc),
        .wrap (wrap)
    );

    assign ch_out   = acc[ACC_W-1];
    assign busy     = (state_q != IDLE);
    assign tw_ready = ~pend_vld;
    assign capture  = tw_valid & ~pend_vld;

    assign period_inc = period_q + 1'b1;
    assign burst_end  = (burst_q != '0) && (period_inc == burst_q);
    assign zero_next  = pend_vld && (tw_pend == '0);

    always_comb begin
        state_d    = state_q;
        apply_pend = 1'b0;
        case (state_q)
            IDLE: begin
                apply_pend = pend_vld;
                if (start && (tw_active != '0)) state_d = RUN;
            end
            RUN: begin
                apply_pend = wrap & pend_vld;
                // A stop landing on a wrap has already reached the period end.
                if (wrap && (burst_end || zero_next || stop)) state_d = IDLE;
                else if (stop)                                state_d = DRAIN;
            end
            DRAIN: begin
                apply_pend = wrap & pend_vld;
                if (wrap) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign acc_en  = (state_q != IDLE);
    assign acc_clr = (state_d == IDLE);

    always_ff @(posedge sys_clk_50m or posedge sys_rst) begin
        if (sys_rst) begin
            state_q   <= IDLE;
            done      <= 1'b0;
            pend_vld  <= 1'b0;
            tw_active <= '0;
            period_q  <= '0;
            ch_out_p1 <= 1'b0;
            edge_cnt  <= '0;
        end else begin
            state_q <= state_d;
            done    <= (state_q != IDLE) && (state_d == IDLE);

            if (apply_pend) begin
                tw_active <= tw_pend;
                pend_vld  <= 1'b0;
            end else if (capture) begin
                pend_vld  <= 1'b1;
            end

            if (state_q == IDLE && state_d == RUN) period_q <= '0;
            else if (state_q == RUN && wrap)       period_q <= period_inc;

            ch_out_p1 <= ch_out;
            if (clr_cnt)                 edge_cnt <= '0;
            else if (ch_out && !ch_out_p1) edge_cnt <= edge_cnt + 1'b1;
        end
    end

    // Data-only registers: qualified by pend_vld / state, so no reset needed.
    always_ff @(posedge sys_clk_50m) begin
        if (capture)                           tw_pend <= sat_tw(tw_in);
        if (state_q == IDLE && state_d == RUN) burst_q <= burst_len;
    end

endmodule

// File: tb/tb_freq_gen_nco.sv
// Scoreboard bench for freq_gen_nco: stimulus queues expected ch_out per busy cycle,
// a negedge monitor pops and compares, and directed checks cover control outputs.
module tb_freq_gen_nco;

    logic        sys_clk_50m = 1'b0;
    logic        sys_rst     = 1'b1;
    logic [31:0] tw_in       = '0;
    logic        tw_valid    = 1'b0;
    logic        tw_ready;
    logic [31:0] burst_len   = '0;
    logic        start       = 1'b0;
    logic        stop        = 1'b0;
    logic        clr_cnt     = 1'b0;
    logic        busy;
    logic        done;
    logic        ch_out;
    logic [63:0] edge_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int done_seen = 0;
    int d0;
    bit exp_ch[$];
    bit exp_bit;

    freq_gen_nco dut (
        .sys_clk_50m (sys_clk_50m),
        .sys_rst     (sys_rst),
        .tw_in       (tw_in),
        .tw_valid    (tw_valid),
        .tw_ready    (tw_ready),
        .burst_len   (burst_len),
        .start       (start),
        .stop        (stop),
        .clr_cnt     (clr_cnt),
        .busy        (busy),
        .done        (done),
        .ch_out      (ch_out),
        .edge_cnt    (edge_cnt)
    );

    always #10 sys_clk_50m = ~sys_clk_50m;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge sys_clk_50m) begin
        if (!sys_rst && done) done_seen++;
        if (!sys_rst && busy) begin
            if (exp_ch.size() == 0) begin
                check("busy_beyond_expected", 64'(busy), 64'd0);
            end else begin
                exp_bit = exp_ch.pop_front();
                check("ch_out_seq", 64'(ch_out), 64'(exp_bit));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk_50m);
        #1;
    endtask

    task automatic push_sq(input int periods, input int len);
        for (int p = 0; p < periods; p++)
            for (int i = 0; i < len; i++)
                exp_ch.push_back(i >= len / 2);
    endtask

    task automatic load_tw(input logic [31:0] v);
        tw_in = v; tw_valid = 1'b1;
        tick(1);
        tw_valid = 1'b0;
        tick(1);
    endtask

    task automatic pulse_start(input logic [31:0] b);
        burst_len = b; start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic clear_cnt();
        clr_cnt = 1'b1;
        tick(1);
        clr_cnt = 1'b0;
    endtask

    task automatic wait_idle(input int limit, input string name);
        int n = 0;
        while (busy && n < limit) begin
            tick(1);
            n++;
        end
        check({name, "_idle"}, 64'(busy), 64'd0);
    endtask

    task automatic end_test(input string name, input logic [63:0] exp_edges);
        tick(2);
        check({name, "_done_pulses"}, 64'(done_seen - d0), 64'd1);
        check({name, "_edge_cnt"}, edge_cnt, exp_edges);
        check({name, "_ch_low"}, 64'(ch_out), 64'd0);
        check({name, "_queue_drained"}, 64'(exp_ch.size()), 64'd0);
        exp_ch.delete();
    endtask

    initial begin
        // Reset state
        #1;
        check("rst_ch_out", 64'(ch_out), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_tw_ready", 64'(tw_ready), 64'd1);
        check("rst_edge_cnt", edge_cnt, 64'd0);
        tick(2);
        sys_rst = 1'b0;
        tick(1);

        // 1: 4-cycle periods, burst of 3
        load_tw(32'h4000_0000);
        push_sq(3, 4);
        d0 = done_seen;
        pulse_start(32'd3);
        wait_idle(40, "t1");
        end_test("t1", 64'd3);
        clear_cnt();
        check("t1_clr_cnt", edge_cnt, 64'd0);

        // 2: continuous 256-cycle period, stop mid-period
        load_tw(32'h0100_0000);
        push_sq(101, 256);
        d0 = done_seen;
        pulse_start(32'd0);
        tick(25663);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        check("t2_edge_cnt_at_stop", edge_cnt, 64'd100);
        check("t2_busy_draining", 64'(busy), 64'd1);
        wait_idle(400, "t2");
        end_test("t2", 64'd101);
        clear_cnt();

        // 3: retune mid-period, second word stalls, then zero word ends the run
        load_tw(32'h4000_0000);
        push_sq(2, 4);
        push_sq(1, 8);
        d0 = done_seen;
        pulse_start(32'd0);
        tick(4);
        tw_in = 32'h2000_0000; tw_valid = 1'b1;
        tick(1);
        tw_in = 32'h0000_0000;
        check("t3_ready_after_capture", 64'(tw_ready), 64'd0);
        tick(2);
        check("t3_ready_held", 64'(tw_ready), 64'd0);
        tick(1);
        check("t3_ready_after_wrap", 64'(tw_ready), 64'd1);
        tick(1);
        tw_valid = 1'b0;
        check("t3_second_word_taken", 64'(tw_ready), 64'd0);
        wait_idle(40, "t3");
        end_test("t3", 64'd3);
        clear_cnt();

        // 4: stop during high phase drains to a full period
        load_tw(32'h1000_0000);
        push_sq(1, 16);
        d0 = done_seen;
        pulse_start(32'd0);
        tick(11);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        check("t4_busy_after_stop", 64'(busy), 64'd1);
        check("t4_high_after_stop", 64'(ch_out), 64'd1);
        wait_idle(40, "t4");
        end_test("t4", 64'd1);
        clear_cnt();

        // 5: clamped word toggles each clock; zero word captured on a wrap; clr beats increment
        load_tw(32'hFFFF_FFFF);
        push_sq(3, 2);
        d0 = done_seen;
        pulse_start(32'd0);
        tick(3);
        tw_in = 32'h0000_0000; tw_valid = 1'b1; clr_cnt = 1'b1;
        tick(1);
        tw_valid = 1'b0; clr_cnt = 1'b0;
        check("t5_clr_priority", edge_cnt, 64'd0);
        check("t5_ready_low", 64'(tw_ready), 64'd0);
        wait_idle(40, "t5");
        end_test("t5", 64'd1);
        clear_cnt();

        // 6: asynchronous reset mid-burst, then start with zero word is ignored
        load_tw(32'h4000_0000);
        exp_ch.push_back(1'b0); exp_ch.push_back(1'b0);
        exp_ch.push_back(1'b1); exp_ch.push_back(1'b1);
        exp_ch.push_back(1'b0); exp_ch.push_back(1'b0);
        d0 = done_seen;
        pulse_start(32'd10);
        tick(5);
        tw_in = 32'h1000_0000; tw_valid = 1'b1;
        tick(1);
        tw_valid = 1'b0;
        check("t6_ready_low_pre_rst", 64'(tw_ready), 64'd0);
        check("t6_edge_cnt_pre_rst", edge_cnt, 64'd1);
        #2;
        sys_rst = 1'b1;
        #1;
        check("t6_rst_ch_out", 64'(ch_out), 64'd0);
        check("t6_rst_edge_cnt", edge_cnt, 64'd0);
        check("t6_rst_tw_ready", 64'(tw_ready), 64'd1);
        check("t6_rst_busy", 64'(busy), 64'd0);
        tick(2);
        sys_rst = 1'b0;
        tick(1);
        check("t6_no_done", 64'(done_seen - d0), 64'd0);
        check("t6_queue_drained", 64'(exp_ch.size()), 64'd0);
        exp_ch.delete();
        pulse_start(32'd10);
        for (int i = 0; i < 3; i++) begin
            check("t6_start_ignored", 64'(busy), 64'd0);
            tick(1);
        end
        check("t6_no_done_after_start", 64'(done_seen - d0), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/freq_gen_nco.md
Name: freq_gen_nco

Overview:
Programmable square-wave generator, the transmit-side counterpart of the channel frequency counter. A phase accumulator (NCO) clocked by sys_clk_50m drives ch_out. Frequency is set by a tuning word, changed glitch-free only at period boundaries. Supports continuous or N-period burst output, plus a rising-edge counter for loopback self-test against the frequency counter.

Parameters:
ACC_W, 32, phase accumulator width; f_out = tw * CLK_HZ / 2^ACC_W
CLK_HZ, 50_000_000, system clock frequency (documentation/bench use only)
CNT_W, 64, width of edge_cnt

Ports:
sys_clk_50m  in   1      single system clock
sys_rst      in   1      asynchronous, active-high reset
tw_in        in   ACC_W  tuning word
tw_valid     in   1      tw_in valid; accepted when tw_valid & tw_ready
tw_ready     out  1      high when the pending-word slot is empty
burst_len    in   32     periods per burst; 0 = continuous; sampled on start
start        in   1      one-cycle start request
stop         in   1      one-cycle stop request (drain to period end)
clr_cnt      in   1      synchronous clear of edge_cnt
busy         out  1      high in RUN or DRAIN
done         out  1      one-cycle pulse on return to IDLE
ch_out       out  1      generated square wave = acc[ACC_W-1], registered
edge_cnt     out  CNT_W  rising edges of ch_out, wraps modulo 2^CNT_W

Behaviour:
- Reset (async, immediate): acc=0, ch_out=0, tw_active=0, pending empty, tw_ready=1, busy=0, done=0, edge_cnt=0, state IDLE.
- Capture: on tw_valid&tw_ready, tw_in is clamped to max 2^(ACC_W-1) and stored as pending; tw_ready drops until pending is applied.
- In IDLE, pending is applied on the next cycle.
- In RUN/DRAIN, pending is applied only in the wrap cycle (carry out of acc+tw_active).
- States:
  - IDLE: acc held 0, ch_out=0.
    - start & tw_active!=0 -> RUN; acc=0 on entry; burst_len latched; period counter = 0.
    - start with tw_active==0 is ignored.
    - stop is ignored.
  - RUN: each cycle acc <= acc + tw_active (modulo 2^ACC_W).
    - Wrap cycle: increment period counter. If burst_len!=0 and the count reaches burst_len -> IDLE. If pending==0 is applied -> IDLE. Else stay.
    - stop -> DRAIN.
  - DRAIN: keep accumulating. At the next wrap -> IDLE. Pending is applied but irrelevant.
- Every RUN/DRAIN -> IDLE transition pulses done for exactly 1 cycle, in the first IDLE cycle.
- Waveform: acc starts at 0, so each period is low first, then high, and ends on a falling edge at wrap. Stopping at wrap never produces a runt pulse.
- ch_out is acc MSB straight from a register, so there is 0 combinational logic on the output.
- Duty cycle: exactly 50% when tw divides 2^ACC_W; otherwise jitter is at most 1 cycle.
- Clamp value 2^(ACC_W-1) makes ch_out toggle every clock (25 MHz).
- Simultaneous events:
  - stop in the same cycle as the final burst wrap or a zero-tw wrap -> IDLE directly, single done.
  - start while busy is ignored.
  - tw_valid on a wrap cycle with pending empty: the word is captured and applied at the next wrap, not the current one.
- edge_cnt increments on each 0->1 of ch_out. clr_cnt has priority over increment in the same cycle.
- Reset mid-burst: output forced low immediately; no done pulse.

Decomposition:
- Shared package/include holds:
  - state encoding: IDLE=2'd0, RUN=2'd1, DRAIN=2'd2
  - ACC_W default
  - TW_MAX = 2^(ACC_W-1)
- Sub-module nco_phase_acc holds the accumulator register, adder and wrap (carry) flag, with an enable and sync clear.
- The top level holds the FSM, pending/active tuning-word registers, burst counter and edge counter.

Test Plan:
1. tw=0x4000_0000, burst_len=3, start -> ch_out pattern 0,0,1,1 repeated 3 times (12 busy cycles); done pulses once; edge_cnt=3; ch_out=0 after.
2. tw=0x0100_0000, burst_len=0, start, run 25600 cycles, stop -> period 256 cycles, 128 high; edge_cnt=100 at stop; done at next wrap.
3. Running at tw=0x4000_0000; mid-period write tw=0x2000_0000 -> current 4-cycle period completes, then 8-cycle periods (4 low/4 high); tw_ready low from capture to that wrap; a second tw_valid stalls meanwhile.
4. tw=0x1000_0000 (16-cycle period); stop asserted during the high phase -> high phase completes to full 8 cycles, falls at wrap, done, busy=0; no runt pulse.
5. tw_in=0xFFFF_FFFF -> stored 0x8000_0000; ch_out toggles every cycle. Then write tw=0 -> returns to IDLE at the next wrap with a done pulse.
6. Assert sys_rst asynchronously mid-burst -> ch_out=0, edge_cnt=0, tw_ready=1, busy=0 with no clock edge; no done pulse. Start after reset with tw_active=0 is ignored.
